out_uart_tx: RTL and testbench

Sink for the core's byte output stream (out_en/out_data strobe). Buffers bytes in a small FIFO and serializes them as UART 8N1 on a single tx pin. Provides out_full back-pressure so the core can stall its output instruction instead of losing bytes. Instantiated beside the cpu top, wired to its out_en/out_data.

---
 rtl/out_uart_pkg.sv | 25 ++
 rtl/out_uart_tx_fifo.sv | 57 +++++
 rtl/out_uart_tx.sv | 148 ++++++++++++++
 tb/tb_out_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_uart_pkg.sv
// Shared types and constants for the byte-stream UART transmitter.
package out_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

   // Line level that belongs to a given frame phase.
   function automatic logic line_level(input tx_state_t st, input logic data_bit);
      logic lvl;
      case (st)
         START:   lvl = 1'b0;
         DATA:    lvl = data_bit;
         default: lvl = 1'b1;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/out_uart_tx_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on dout without a read cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Guard the strobes so a caller can never corrupt pointers or count.
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   // Pointer and occupancy bookkeeping; pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == (PTR_W+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

// File: rtl/out_uart_tx.sv
// Byte-stream sink: buffers core output bytes and sends them as UART 8N1.
module out_uart_tx
   import out_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       out_en,
   input  logic [7:0] out_data,
   output logic       out_full,
   output logic       tx,
   output logic       busy,
   output logic       overflow
);

   localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);
   localparam int              CNT_FW    = $clog2(FIFO_DEPTH) + 1;

   logic              w_full;
   logic              w_empty;
   logic [7:0]        w_dout;
   logic [CNT_FW-1:0] w_count;
   logic              w_push;
   logic              w_pop;
   logic              w_baud_last;

   tx_state_t         r_state;
   logic [CNT_W-1:0]  r_baud_cnt;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_tx;
   logic              r_overflow;

   tx_state_t         w_state_nxt;
   logic [CNT_W-1:0]  w_baud_nxt;
   logic [2:0]        w_bit_nxt;
   logic [7:0]        w_shift_nxt;
   logic              w_tx_nxt;

   // Full is judged on the registered count, before any same-cycle pop.
   assign w_push      = out_en & ~w_full;
   assign w_baud_last = (r_baud_cnt == BAUD_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clock),
      .rst_n (reset_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (out_data),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Frame sequencing: next state, baud/bit counters, shift register and pop.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud_cnt;
      w_bit_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_dout;
               w_baud_nxt  = '0;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_baud_last) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = DATA;
            end else begin
               w_baud_nxt = r_baud_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (w_baud_last) begin
               w_baud_nxt  = '0;
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_idx == BIT_LAST) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (w_baud_last) begin
               w_baud_nxt = '0;
               // Chain straight into the next frame when more bytes wait.
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_dout;
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_baud_nxt = r_baud_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Line level is computed from the upcoming phase so tx is a clean flop.
      w_tx_nxt = line_level(w_state_nxt, w_shift_nxt[0]);
   end

   // State, counters, registered line output and sticky overflow.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         if (out_en && w_full) r_overflow <= 1'b1;
      end
   end

   assign tx       = r_tx;
   assign out_full = w_full;
   assign overflow = r_overflow;
   assign busy     = (r_state != IDLE) | (w_count != '0);

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: directed scenarios plus random traffic against a queue model.
module tb_out_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] data;
   logic       out_full;
   logic       tx;
   logic       busy;
   logic       overflow;

   int n_vec = 0;
   int n_err = 0;

   out_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock    (clk),
      .reset_n  (rst_n),
      .out_en   (en),
      .out_data (data),
      .out_full (out_full),
      .tx       (tx),
      .busy     (busy),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: pending bytes in a queue, the frame on the line as (byte, cycle offset).
   logic [7:0] m_q[$];
   logic       m_active  = 1'b0;
   logic [7:0] m_cur     = 8'h00;
   int         m_off     = 0;
   logic       m_ovf     = 1'b0;
   logic       m_started = 1'b0;

   function automatic logic exp_level(input logic [7:0] b, input int off);
      int pos;
      pos = off / CPB;
      if (pos == 0) return 1'b0;
      if (pos >= 9) return 1'b1;
      return b[pos-1];
   endfunction

   always @(posedge clk) begin
      logic was_full;
      m_started = 1'b1;
      if (!rst_n) begin
         m_q.delete();
         m_active = 1'b0;
         m_off    = 0;
         m_ovf    = 1'b0;
      end else begin
         was_full = (m_q.size() == DEPTH);
         if (m_active) begin
            if (m_off == FRAME - 1) begin
               if (m_q.size() > 0) begin
                  m_cur = m_q.pop_front();
                  m_off = 0;
               end else begin
                  m_active = 1'b0;
               end
            end else begin
               m_off++;
            end
         end else if (m_q.size() > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_off    = 0;
         end
         if (en) begin
            if (was_full) m_ovf = 1'b1;
            else          m_q.push_back(data);
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("tx",       tx,       m_active ? exp_level(m_cur, m_off) : 1'b1);
         chk("busy",     busy,     m_active || (m_q.size() != 0));
         chk("out_full", out_full, m_q.size() == DEPTH);
         chk("overflow", overflow, m_ovf);
      end
   end

   task automatic push_byte(input logic [7:0] b);
      en   = 1'b1;
      data = b;
      @(negedge clk);
      en   = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("drain", busy, 1'b0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic found;
      int   sent;
      rst_n = 1'b0;
      en    = 1'b0;
      data  = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tx",   tx,       1'b1);
      chk("rst_full", out_full, 1'b0);
      chk("rst_busy", busy,     1'b0);
      chk("rst_ovf",  overflow, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte and start latency
      push_byte(8'h41);
      chk("lat_pre",   tx, 1'b1);
      @(negedge clk);
      chk("lat_start", tx, 1'b0);
      wait_idle(60);

      // Back-to-back frames
      en = 1'b1; data = 8'h00;
      @(negedge clk);
      data = 8'hFF;
      @(negedge clk);
      en = 1'b0;
      wait_idle(120);

      // Fill and back-pressure: sixth byte dropped
      for (int i = 0; i < 6; i++) begin
         en   = 1'b1;
         data = 8'h10 + 8'(i);
         @(negedge clk);
      end
      en = 1'b0;
      chk("fill_full", out_full, 1'b1);
      chk("fill_ovf",  overflow, 1'b1);
      wait_idle(300);
      pulse_reset();

      // Push exactly on the STOP-to-START pop edge while full
      for (int i = 0; i < 5; i++) begin
         en   = 1'b1;
         data = 8'hA0 + 8'(i);
         @(negedge clk);
      end
      en    = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (m_active && m_off == FRAME - 1 && m_q.size() == DEPTH) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("wait_popedge", found, 1'b1);
      if (found) begin
         en   = 1'b1;
         data = 8'hEE;
         @(negedge clk);
         en   = 1'b0;
         chk("popedge_ovf",  overflow, 1'b1);
         chk("popedge_full", out_full, 1'b0);
      end
      wait_idle(300);
      pulse_reset();

      // Reset in the middle of a frame
      push_byte(8'h55);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_tx",   tx,   1'b1);
      chk("mid_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("mid_quiet", tx, 1'b1);

      // Stream with back-pressure honoured: pointers wrap many times
      sent = 0;
      for (int i = 0; i < 5000 && sent < 40; i++) begin
         if (out_full) begin
            en = 1'b0;
         end else begin
            en   = 1'b1;
            data = 8'(sent);
            sent++;
         end
         @(negedge clk);
      end
      en = 1'b0;
      chk("stream_sent", sent, 40);
      wait_idle(400);
      chk("stream_ovf", overflow, 1'b0);

      // Random traffic with occasional ignored back-pressure and resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            en    = 1'b0;
         end else begin
            rst_n = 1'b1;
            en    = ($urandom_range(0, 15) == 0) &&
                    (!out_full || $urandom_range(0, 3) == 0);
            data  = 8'($urandom);
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      en    = 1'b0;
      wait_idle(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
